led_pattern_addr_gen: RTL



---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_seq_prescaler.sv | 29 ++
 rtl/led_pattern_addr_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// Shared definitions for the slow LED pattern sequencers: sequencer state
// encoding, default address width, system clock rate and a helper that turns
// a desired step rate into a prescaler count.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_WARM  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_t;

  localparam int          ADDR_W_DEF = 12;
  localparam int unsigned CLK_HZ     = 200_000_000;

  // Clock cycles per step for a requested step rate in Hz; rates at or above
  // the clock rate (or zero) collapse to one step per cycle.
  function automatic int unsigned prescale_for(input int unsigned step_hz);
    int unsigned cyc;
    if (step_hz == 0 || step_hz >= CLK_HZ) cyc = 1;
    else                                    cyc = CLK_HZ / step_hz;
    return cyc;
  endfunction

endpackage

// File: rtl/led_seq_prescaler.sv
// Free-running divide-by-PRESCALE counter with count enable and synchronous
// clear. tc is high while the count sits on its last value, so the owner sees
// the wrap on the same edge the counter returns to zero.
module led_seq_prescaler #(
  parameter int unsigned PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam logic [31:0] TC_VAL = PRESCALE - 1;

  logic [31:0] count;

  assign tc = (count == TC_VAL);

  // Count 0..PRESCALE-1 while enabled; hold otherwise; clear wins over counting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= tc ? '0 : count + 32'd1;
  end

endmodule

// File: rtl/led_pattern_addr_gen.sv
// Address sequencer for the LED pattern ROM (1-cycle read latency, output
// zero while disabled). Holds the ROM disabled for WARM_CYC cycles after
// reset, then walks the address up or down once per PRESCALE cycles, with
// pause/resume and a synchronous address load. upd marks the cycle the ROM
// output first reflects a new address.
// Optional feature: define LED_SEQ_STEP_EN to add the step input, which
// single-steps the address while paused.
module led_pattern_addr_gen
  import led_seq_pkg::*;
#(
  parameter int          ADDR_W     = ADDR_W_DEF,
  parameter int unsigned PRESCALE   = 50_000_000,
  parameter int          WARM_CYC   = 16,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              dir,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
`ifdef LED_SEQ_STEP_EN
  input  logic              step,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              en,
  output logic              tick,
  output logic              upd
);

  localparam logic [7:0]        WARM_LAST = 8'(WARM_CYC - 1);
  localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(START_ADDR);

  seq_state_t        state, state_nxt;
  logic [7:0]        wc;
  logic              pc_tc;
  logic              timed_step;
  logic              manual_step;
  logic              do_step;
  logic [ADDR_W-1:0] addr_nxt;
  logic              addr_chg_q;
  logic              warm_exit_q;

  // Step timer: advances only in RUN; a load restarts the step period.
  led_seq_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_RUN),
    .clr (load),
    .tc  (pc_tc)
  );

  // Next-state logic: warm-up exit, then run/pause follows the run input.
  // NOTE: every output of a combinational block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WARM:  if (wc == WARM_LAST) state_nxt = run ? ST_RUN : ST_PAUSE;
      ST_RUN:   if (!run)            state_nxt = ST_PAUSE;
      ST_PAUSE: if (run)             state_nxt = ST_RUN;
      default:                       state_nxt = ST_WARM;
    endcase
  end

  // Address update: load beats any step; a step moves one place per dir.
  always_comb begin
    timed_step = (state == ST_RUN) && pc_tc && !load;
`ifdef LED_SEQ_STEP_EN
    manual_step = (state == ST_PAUSE) && step && !load;
`else
    manual_step = 1'b0;
`endif
    do_step  = timed_step || manual_step;
    addr_nxt = addr;
    if (load)         addr_nxt = load_addr;
    else if (do_step) addr_nxt = dir ? addr - 1'b1 : addr + 1'b1;
  end

  // State register and warm-up counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_WARM;
      wc    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WARM) wc <= wc + 8'd1;
    end
  end

  // Registered outputs; upd trails an address change (or warm-up exit) by one
  // cycle to line up with the ROM read latency, and only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr        <= ADDR_RST;
      en          <= 1'b0;
      tick        <= 1'b0;
      upd         <= 1'b0;
      addr_chg_q  <= 1'b0;
      warm_exit_q <= 1'b0;
    end else begin
      addr        <= addr_nxt;
      en          <= (state_nxt != ST_WARM);
      tick        <= timed_step;
      addr_chg_q  <= load || do_step;
      warm_exit_q <= (state == ST_WARM) && (state_nxt != ST_WARM);
      upd         <= en && (addr_chg_q || warm_exit_q);
    end
  end

endmodule
